if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Fetch-side consumer of the hazard detection unit's control outputs: owns the program counter, the instruction-memory address, and the IF/ID pipeline buffer. Applies PC_Hold, IF_ID_Hold and branch redirects each cycle, inserts NOP bubbles into IF/ID on a taken branch, latches exception state from ExcepSig, and counts stall cycles. Sits between instruction memory and the decode stage.

## Interface
- PC_WIDTH, 16, PC and address width
- INSTR_WIDTH, 16, instruction width
- PC_STEP, 2, PC increment per fetch (byte-addressed, 16-bit instructions)
- RESET_PC, 0, PC value after reset
- NOP_INSTR, 16'h0000, encoding injected into IF/ID on flush
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- PC_Hold  in  1  1 = PC keeps its value this cycle
- IF_ID_Hold  in  1  load enable despite the name: 1 = IF/ID loads, 0 = IF/ID keeps contents
- branch  in  1  taken branch/jump resolved this cycle
- branch_target  in  PC_WIDTH  redirect address, valid when branch=1
- ExcepSig  in  1  exception raised downstream this cycle
- exc_clear  in  1  clears the exception latch
- imem_data  in  INSTR_WIDTH  instruction at imem_addr (combinational read)
- imem_addr  out  PC_WIDTH  equals current PC
- if_id_instr  out  INSTR_WIDTH  registered instruction to decode
- if_id_pc  out  PC_WIDTH  registered PC+PC_STEP of that instruction
- if_id_valid  out  1  0 = bubble
- exc_flag  out  1  sticky exception indicator
- exc_pc  out  PC_WIDTH  if_id_pc captured on first exception
- stall_count  out  16  saturating count of PC_Hold cycles
- fetch_state  out  2  FSM state encoding

## Operation
- FSM states: RUN (2'b00), REDIRECT (2'b01), EXC (2'b10).
- Per-cycle priority: rst > PC_Hold > branch > normal advance.
- PC_Hold=1: PC unchanged; branch ignored this cycle (upstream re-presents it); IF/ID follows IF_ID_Hold; stall_count += 1, saturating at 16'hFFFF.
- PC_Hold=0, branch=1: PC <= branch_target; IF/ID <= {NOP_INSTR, valid=0}, regardless of IF_ID_Hold; state -> REDIRECT for exactly one cycle.
- REDIRECT: normal fetch from new PC; return to RUN (or EXC if exc_flag set). Branch in REDIRECT is honored identically (back-to-back redirect stays in REDIRECT).
- Normal (PC_Hold=0, branch=0): PC <= PC+PC_STEP, wrapping modulo 2^PC_WIDTH; if IF_ID_Hold=1, IF/ID <= {imem_data, PC+PC_STEP, valid=1}.
- PC_Hold=0 with IF_ID_Hold=0 and no branch: illegal from hazard unit; the PC still advances, IF/ID holds, and the fetched instruction is dropped. Verify it as defined behaviour; no assertion is raised in RTL.
- ExcepSig=1 while exc_flag=0: exc_flag <= 1, exc_pc <= if_id_pc, state -> EXC. Later exceptions do not overwrite exc_pc. Fetch continues; exceptions are reported, not acted on.
- exc_clear=1: exc_flag <= 0, state -> RUN. If ExcepSig is asserted in the same cycle, the new exception wins: flag stays set and exc_pc is recaptured.

## Timing
- Reset values: PC=RESET_PC, imem_addr=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, exc_flag=0, exc_pc=0, stall_count=0, fetch_state=RUN.
- Fetch latency: imem_addr to if_id_instr takes 1 cycle.
- Branch penalty at this block: 1 bubble. The instruction already in IF/ID is squashed by the hazard unit's Delay, not here.
- rst during REDIRECT or EXC: all state returns to reset values on that edge.
- All outputs are registered, except imem_addr, which is taken directly from the PC register.

## Structure
- Shared package `cpu_pkg`: PC_WIDTH, INSTR_WIDTH, NOP_INSTR, fetch_state encodings (FS_RUN, FS_REDIRECT, FS_EXC).
- One natural sub-module, `if_id_reg`: the IF/ID buffer with load-enable and flush inputs, reusable for other stage buffers.
- PC register, FSM, exception latch and stall counter live in the top module.

## Test plan
- Reset then 4 free-run cycles, imem_data=16'h1234: imem_addr 0,2,4,6; if_id_valid=1 from cycle 1; if_id_pc=2 on the first valid.
- PC_Hold=1, IF_ID_Hold=0 for 3 cycles at PC=8: PC stays 8, IF/ID unchanged, stall_count=3. After release, PC=10.
- branch=1, branch_target=16'h0040 at PC=12: next PC=16'h0040, if_id_valid=0, if_id_instr=NOP_INSTR, fetch_state=REDIRECT for 1 cycle, then RUN.
- branch=1 together with PC_Hold=1: PC unchanged, no flush. branch=1 the next cycle with PC_Hold=0: redirect taken.
- PC=16'hFFFE free-running: next PC=16'h0000.
- ExcepSig at if_id_pc=6, then at 10: exc_pc stays 6. exc_clear with ExcepSig at if_id_pc=14: exc_flag stays 1, exc_pc=14. Reset in EXC: all outputs return to reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, NOP encoding and fetch FSM state encodings
package cpu_pkg;
    localparam int PC_WIDTH = 16;
    localparam int INSTR_WIDTH = 16;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0000;
    typedef enum logic [1:0] {
        FS_RUN      = 2'b00,
        FS_REDIRECT = 2'b01,
        FS_EXC      = 2'b10
    } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline stage buffer with load enable and flush-to-bubble
module if_id_reg #(
    parameter int IW = 16,
    parameter int PW = 16,
    parameter logic [IW-1:0] NOP = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_flush,
    input  logic [IW-1:0] i_instr,
    input  logic [PW-1:0] i_pc,
    output logic [IW-1:0] o_instr,
    output logic [PW-1:0] o_pc,
    output logic          o_valid
);
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            o_instr <= NOP;
            o_pc    <= '0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_instr <= i_instr;
            o_pc    <= i_pc;
            o_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC, IF/ID buffer, redirect FSM, exception latch and stall counter
module if_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = cpu_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int PC_STEP = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PC_Hold,
    input  logic                   IF_ID_Hold,
    input  logic                   branch,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   ExcepSig,
    input  logic                   exc_clear,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic                   if_id_valid,
    output logic                   exc_flag,
    output logic [PC_WIDTH-1:0]    exc_pc,
    output logic [15:0]            stall_count,
    output logic [1:0]             fetch_state
);
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_exc_pc;
    logic [15:0]         r_stall;
    logic                r_exc_flag;
    fetch_state_t        r_state;
    logic [PC_WIDTH-1:0] w_pc_seq;
    logic                w_redirect;
    logic                w_exc_set;
    logic                w_exc_next;

    assign w_pc_seq   = r_pc + PC_WIDTH'(PC_STEP);
    assign w_redirect = !PC_Hold && branch;
    // a new exception outranks a simultaneous clear and recaptures exc_pc
    assign w_exc_set  = ExcepSig && (!r_exc_flag || exc_clear);
    assign w_exc_next = w_exc_set || (r_exc_flag && !exc_clear);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_stall    <= '0;
            r_exc_flag <= 1'b0;
            r_exc_pc   <= '0;
            r_state    <= FS_RUN;
        end else begin
            if (!PC_Hold)
                r_pc <= branch ? branch_target : w_pc_seq;
            if (PC_Hold && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
            r_exc_flag <= w_exc_next;
            if (w_exc_set)
                r_exc_pc <= if_id_pc;
            r_state <= w_redirect ? FS_REDIRECT : (w_exc_next ? FS_EXC : FS_RUN);
        end
    end

    if_id_reg #(
        .IW (INSTR_WIDTH),
        .PW (PC_WIDTH),
        .NOP(NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .i_load (IF_ID_Hold),
        .i_flush(w_redirect),
        .i_instr(imem_data),
        .i_pc   (w_pc_seq),
        .o_instr(if_id_instr),
        .o_pc   (if_id_pc),
        .o_valid(if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign exc_flag    = r_exc_flag;
    assign exc_pc      = r_exc_pc;
    assign stall_count = r_stall;
    assign fetch_state = r_state;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed vectors with a queued scoreboard checked after each edge
module tb_if_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PC_Hold = 1'b0;
    logic        IF_ID_Hold = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] branch_target = '0;
    logic        ExcepSig = 1'b0;
    logic        exc_clear = 1'b0;
    logic [15:0] imem_data = '0;
    logic [15:0] imem_addr;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        exc_flag;
    logic [15:0] exc_pc;
    logic [15:0] stall_count;
    logic [1:0]  fetch_state;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] ipc;
        logic        v;
        logic        ef;
        logic [15:0] epc;
        logic [15:0] st;
        logic [1:0]  fs;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_id = 0;

    localparam logic [1:0] RUN = 2'b00, RED = 2'b01, EXC = 2'b10;

    if_fetch_ctrl dut (
        .clk(clk), .rst(rst), .PC_Hold(PC_Hold), .IF_ID_Hold(IF_ID_Hold),
        .branch(branch), .branch_target(branch_target), .ExcepSig(ExcepSig),
        .exc_clear(exc_clear), .imem_data(imem_data), .imem_addr(imem_addr),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .exc_flag(exc_flag), .exc_pc(exc_pc), .stall_count(stall_count),
        .fetch_state(fetch_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            a = '{imem_addr, if_id_instr, if_id_pc, if_id_valid, exc_flag, exc_pc, stall_count, fetch_state};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL vec%0d: got pc=%h instr=%h ipc=%h v=%b ef=%b epc=%h st=%h fs=%b, want pc=%h instr=%h ipc=%h v=%b ef=%b epc=%h st=%h fs=%b",
                    n_vec, a.pc, a.instr, a.ipc, a.v, a.ef, a.epc, a.st, a.fs,
                    e.pc, e.instr, e.ipc, e.v, e.ef, e.epc, e.st, e.fs);
            end
        end
    end

    task automatic vec(input logic r, h, ih, b, input logic [15:0] t, input logic ex, cl,
                       input logic [15:0] d, input logic [15:0] pc, ins, ipc, input logic v, ef,
                       input logic [15:0] epc, st, input logic [1:0] fs);
        @(negedge clk);
        rst = r; PC_Hold = h; IF_ID_Hold = ih; branch = b; branch_target = t;
        ExcepSig = ex; exc_clear = cl; imem_data = d;
        q.push_back('{pc, ins, ipc, v, ef, epc, st, fs});
        n_id++;
    endtask

    initial begin
        //  rst h ih b  tgt       ex cl data      | pc        instr     ipc       v  ef epc    stall  fs
        vec(1, 0, 0, 0, 16'h0000, 0, 0, 16'h1234,  16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd0, RUN);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h1234,  16'h0002, 16'h1234, 16'h0002, 1, 0, 16'd0, 16'd0, RUN);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h1234,  16'h0004, 16'h1234, 16'h0004, 1, 0, 16'd0, 16'd0, RUN);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h1234,  16'h0006, 16'h1234, 16'h0006, 1, 0, 16'd0, 16'd0, RUN);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h1234,  16'h0008, 16'h1234, 16'h0008, 1, 0, 16'd0, 16'd0, RUN);
        // stall at PC=8 with IF/ID frozen
        vec(0, 1, 0, 0, 16'h0000, 0, 0, 16'h5555,  16'h0008, 16'h1234, 16'h0008, 1, 0, 16'd0, 16'd1, RUN);
        vec(0, 1, 0, 0, 16'h0000, 0, 0, 16'h5555,  16'h0008, 16'h1234, 16'h0008, 1, 0, 16'd0, 16'd2, RUN);
        vec(0, 1, 0, 0, 16'h0000, 0, 0, 16'h5555,  16'h0008, 16'h1234, 16'h0008, 1, 0, 16'd0, 16'd3, RUN);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h2222,  16'h000A, 16'h2222, 16'h000A, 1, 0, 16'd0, 16'd3, RUN);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h3333,  16'h000C, 16'h3333, 16'h000C, 1, 0, 16'd0, 16'd3, RUN);
        // taken branch at PC=12
        vec(0, 0, 1, 1, 16'h0040, 0, 0, 16'h4444,  16'h0040, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd3, RED);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h5656,  16'h0042, 16'h5656, 16'h0042, 1, 0, 16'd0, 16'd3, RUN);
        // branch under PC_Hold is ignored, then taken, then back-to-back
        vec(0, 1, 0, 1, 16'h0080, 0, 0, 16'h7777,  16'h0042, 16'h5656, 16'h0042, 1, 0, 16'd0, 16'd4, RUN);
        vec(0, 0, 1, 1, 16'h0080, 0, 0, 16'h7777,  16'h0080, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd4, RED);
        vec(0, 0, 1, 1, 16'hFFFC, 0, 0, 16'h7777,  16'hFFFC, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd4, RED);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h8888,  16'hFFFE, 16'h8888, 16'hFFFE, 1, 0, 16'd0, 16'd4, RUN);
        // PC wrap from FFFE
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h9999,  16'h0000, 16'h9999, 16'h0000, 1, 0, 16'd0, 16'd4, RUN);
        // illegal advance without IF/ID load: fetched word dropped
        vec(0, 0, 0, 0, 16'h0000, 0, 0, 16'hAAAA,  16'h0002, 16'h9999, 16'h0000, 1, 0, 16'd0, 16'd4, RUN);
        vec(1, 0, 0, 0, 16'h0000, 0, 0, 16'hAAAA,  16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd0, RUN);
        // exception sequence
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0101,  16'h0002, 16'h0101, 16'h0002, 1, 0, 16'd0, 16'd0, RUN);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0202,  16'h0004, 16'h0202, 16'h0004, 1, 0, 16'd0, 16'd0, RUN);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0303,  16'h0006, 16'h0303, 16'h0006, 1, 0, 16'd0, 16'd0, RUN);
        vec(0, 0, 1, 0, 16'h0000, 1, 0, 16'h0404,  16'h0008, 16'h0404, 16'h0008, 1, 1, 16'd6, 16'd0, EXC);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0505,  16'h000A, 16'h0505, 16'h000A, 1, 1, 16'd6, 16'd0, EXC);
        vec(0, 0, 1, 0, 16'h0000, 1, 0, 16'h0606,  16'h000C, 16'h0606, 16'h000C, 1, 1, 16'd6, 16'd0, EXC);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0707,  16'h000E, 16'h0707, 16'h000E, 1, 1, 16'd6, 16'd0, EXC);
        vec(0, 0, 1, 0, 16'h0000, 1, 1, 16'h0808,  16'h0010, 16'h0808, 16'h0010, 1, 1, 16'd14, 16'd0, EXC);
        vec(0, 0, 1, 0, 16'h0000, 0, 1, 16'h0909,  16'h0012, 16'h0909, 16'h0012, 1, 0, 16'd14, 16'd0, RUN);
        vec(0, 0, 1, 0, 16'h0000, 1, 0, 16'h0A0A,  16'h0014, 16'h0A0A, 16'h0014, 1, 1, 16'd18, 16'd0, EXC);
        vec(0, 0, 1, 1, 16'h0100, 0, 0, 16'h0B0B,  16'h0100, 16'h0000, 16'h0000, 0, 1, 16'd18, 16'd0, RED);
        vec(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0C0C,  16'h0102, 16'h0C0C, 16'h0102, 1, 1, 16'd18, 16'd0, EXC);
        vec(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0D0D,  16'h0102, 16'h0C0C, 16'h0102, 1, 1, 16'd18, 16'd1, EXC);
        // reset while in EXC
        vec(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0E0E,  16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd0, RUN);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0 || n_vec != n_id) begin
            n_bad++;
            $display("FAIL drain: checked %0d of %0d vectors", n_vec, n_id);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
